servo_hold_timer: RTL and testbench



---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_hold_timer_if.sv | 10 +
 rtl/strobe_divider.sv | 25 ++
 rtl/servo_hold_timer.sv | 97 +++++++++
 tb/tb_servo_hold_timer.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the servo hold timer.
// Covers register addresses, duty codes, the state type and the open-duty clamp.
package servo_pkg;

  localparam logic [31:0] DUTY_ADDR   = 32'h0000_1000;
  localparam logic [31:0] HOLD_ADDR   = 32'h0000_1004;
  localparam logic [31:0] STATUS_ADDR = 32'h0000_1008;

  localparam logic [9:0] CLOSED_DUTY       = 10'd40;
  localparam logic [9:0] DEFAULT_OPEN_DUTY = 10'd112;
  localparam logic [9:0] MIN_DUTY          = 10'd25;
  localparam logic [9:0] MAX_DUTY          = 10'd125;

  typedef enum logic [0:0] {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } state_e;

  // Full 16-bit unsigned compare, so large writes saturate rather than alias.
  function automatic logic [9:0] clamp_duty(input logic [15:0] v);
    if (v < {6'd0, MIN_DUTY})      return MIN_DUTY;
    else if (v > {6'd0, MAX_DUTY}) return MAX_DUTY;
    else                           return v[9:0];
  endfunction

endpackage

// File: rtl/servo_hold_timer_if.sv
// CPU-side memory-mapped bus into the servo hold timer.
interface servo_hold_timer_if;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] status_rdata;

  modport master (output mem_wren, mem_addr, mem_data_in, input  status_rdata);
  modport slave  (input  mem_wren, mem_addr, mem_data_in, output status_rdata);
endinterface

// File: rtl/strobe_divider.sv
// Free-running 0..PERIOD-1 counter emitting a 1-cycle strobe on its last count.
module strobe_divider #(
  parameter int PERIOD = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic stb_o
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign stb_o = (cnt_q == CW'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || stb_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/servo_hold_timer.sv
// Holds a CPU-programmed open duty for N ms, then reverts to the closed duty.
// Output duty changes only on PWM frame boundaries.
module servo_hold_timer
  import servo_pkg::*;
#(
  parameter int TICK_CYCLES  = 50000,
  parameter int FRAME_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  servo_hold_timer_if.slave        bus,
  output logic [9:0]               duty_cycle,
  output logic                     busy
);

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [9:0]  open_q, open_d;
  logic [9:0]  duty_q;
  logic        busy_q;
  logic [31:0] status_q, status_d;

  logic        duty_wr, hold_wr, status_rd;
  logic [15:0] hold_val;
  logic        tick, frame_stb;
  logic        unused_hi;

  assign duty_wr   = bus.mem_wren  && (bus.mem_addr == DUTY_ADDR);
  assign hold_wr   = bus.mem_wren  && (bus.mem_addr == HOLD_ADDR);
  assign status_rd = !bus.mem_wren && (bus.mem_addr == STATUS_ADDR);
  assign hold_val  = bus.mem_data_in[15:0];
  assign unused_hi = ^bus.mem_data_in[31:16];

  // Restarting the ms tick on every hold write makes expiry exactly N ticks later.
  strobe_divider #(.PERIOD(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (hold_wr),
    .stb_o   (tick)
  );

  strobe_divider #(.PERIOD(FRAME_CYCLES)) u_frame (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (1'b0),
    .stb_o   (frame_stb)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    open_d  = open_q;
    if (duty_wr) open_d = clamp_duty(hold_val);
    if (hold_wr) begin
      if (hold_val != 16'd0) begin
        rem_d   = hold_val;
        state_d = OPEN;
      end else begin
        rem_d   = '0;
        state_d = CLOSED;
      end
    end else if (state_q == OPEN && tick) begin
      if (rem_q <= 16'd1) begin
        rem_d   = '0;
        state_d = CLOSED;
      end else begin
        rem_d   = rem_q - 16'd1;
      end
    end
  end

  assign status_d = status_rd ? {(state_d == OPEN), 15'd0, rem_d} : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CLOSED;
      rem_q    <= '0;
      open_q   <= DEFAULT_OPEN_DUTY;
      duty_q   <= CLOSED_DUTY;
      busy_q   <= 1'b0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      open_q   <= open_d;
      busy_q   <= (state_d == OPEN);
      status_q <= status_d;
      // Frame samples pre-edge state, so a same-cycle duty write lands next frame.
      if (frame_stb) duty_q <= (state_q == OPEN) ? open_q : CLOSED_DUTY;
    end
  end

  assign duty_cycle       = duty_q;
  assign busy             = busy_q;
  assign bus.status_rdata = status_q;

endmodule

// File: tb/tb_servo_hold_timer.sv
// Directed plus randomized bench for servo_hold_timer against a timeline-based model.
module tb_servo_hold_timer;
  localparam int T = 10;
  localparam int F = 25;
  localparam logic [31:0] A_DUTY = 32'h0000_1000;
  localparam logic [31:0] A_HOLD = 32'h0000_1004;
  localparam logic [31:0] A_STAT = 32'h0000_1008;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] duty_cycle;
  logic       busy;

  servo_hold_timer_if bus ();

  servo_hold_timer #(.TICK_CYCLES(T), .FRAME_CYCLES(F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .duty_cycle (duty_cycle),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the last hold is described by its start edge and length; everything else is arithmetic.
  int          e;
  int          mh, mn;
  int          od;
  logic [9:0]  exp_duty;

  function automatic bit open_after(input int x);
    return (mn > 0) && (x >= mh) && (x < mh + mn * T);
  endfunction

  function automatic int rem_after(input int x);
    return open_after(x) ? (mn - (x - mh) / T) : 0;
  endfunction

  function automatic int clampv(input int v);
    return (v < 25) ? 25 : (v > 125) ? 125 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, expv, e);
    end
  endtask

  task automatic model_reset();
    e = 0; mh = 0; mn = 0; od = 112; exp_duty = 10'd40;
  endtask

  task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit          pre, post;
    int          r;
    logic [31:0] st;
    bus.mem_wren    = wr;
    bus.mem_addr    = a;
    bus.mem_data_in = d;
    @(posedge clk);
    pre = open_after(e - 1);
    if (e % F == F - 1) exp_duty = pre ? 10'(od) : 10'd40;
    if (wr && a == A_DUTY) od = clampv(int'(d[15:0]));
    if (wr && a == A_HOLD) begin mh = e; mn = int'(d[15:0]); end
    post = open_after(e);
    r    = rem_after(e);
    st   = (!wr && a == A_STAT) ? {post, 15'd0, 16'(r)} : 32'd0;
    #1;
    chk("duty",   {22'd0, duty_cycle}, {22'd0, exp_duty});
    chk("busy",   {31'd0, busy},       {31'd0, post});
    chk("status", bus.status_rdata,    st);
    e++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
  endtask

  task automatic reset_release();
    bus.mem_wren = 1'b0; bus.mem_addr = '0; bus.mem_data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    reset_release();
    chk("rst_duty",   {22'd0, duty_cycle}, 32'd40);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_status", bus.status_rdata,    32'd0);

    // Hold N=3 at edge 5: busy rises after edge 5, falls after edge 35
    idle(5);
    step(1'b1, A_HOLD, 32'd3);
    chk("s2_busy_rise", {31'd0, busy}, 32'd1);
    idle(29);
    chk("s2_busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    chk("s2_busy_fall", {31'd0, busy}, 32'd0);
    idle(40);

    // Clamp cases, upper data bits ignored
    step(1'b1, A_DUTY, 32'hABCD_00C8); step(1'b1, A_HOLD, 32'd4); idle(60);
    step(1'b1, A_DUTY, 32'd10);        step(1'b1, A_HOLD, 32'd4); idle(60);
    step(1'b1, A_DUTY, 32'd90);        step(1'b1, A_HOLD, 32'd4); idle(60);
    step(1'b1, A_DUTY, 32'h0001_0000); idle(30);

    // Retrigger after four ticks, then retrigger coincident with a tick
    step(1'b1, A_HOLD, 32'd5); idle(40);
    step(1'b1, A_HOLD, 32'd2); step(1'b0, A_STAT, 0); idle(18);
    chk("s4_busy_pre", {31'd0, busy}, 32'd1);
    idle(1);
    chk("s4_busy_exp", {31'd0, busy}, 32'd0);
    idle(30);
    step(1'b1, A_HOLD, 32'd5); idle(9);
    step(1'b1, A_HOLD, 32'd3); step(1'b0, A_STAT, 0); idle(40);

    // Cancel while open, then status read
    step(1'b1, A_HOLD, 32'd4); idle(12);
    step(1'b1, A_HOLD, 32'd0);
    chk("s5_cancel", {31'd0, busy}, 32'd0);
    step(1'b0, A_STAT, 0);
    chk("s5_status", bus.status_rdata, 32'd0);
    idle(30);

    // Async reset mid-hold with remaining=4
    step(1'b1, A_DUTY, 32'd60);
    step(1'b1, A_HOLD, 32'd5); idle(11);
    step(1'b0, A_STAT, 0);
    chk("s6_rem4", bus.status_rdata, 32'h8000_0004);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_async_duty",   {22'd0, duty_cycle}, 32'd40);
    chk("s6_async_busy",   {31'd0, busy},       32'd0);
    chk("s6_async_status", bus.status_rdata,    32'd0);
    reset_release();
    idle(5);
    step(1'b1, A_HOLD, 32'd3);
    idle(45);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 6)        step(1'b1, A_HOLD, {$urandom_range(0, 65535) & 32'hFFFF_0000} | $urandom_range(0, 6));
      else if (r < 12)  step(1'b1, A_DUTY, (r < 9) ? $urandom : $urandom_range(0, 160));
      else if (r < 40)  step(1'b0, A_STAT, $urandom);
      else if (r < 44)  step(1'b1, A_STAT, $urandom);
      else if (r < 48)  step(1'b1, 32'h0001_1004, $urandom_range(1, 6));
      else              step(1'b0, ($urandom_range(0, 3) == 0) ? A_HOLD : 32'h0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
